uno_player_hand: RTL

//  Holds one player's hand of UNO cards (6b code: [5:4] colour 0R/1Y/2G/3B, [3:0] value 0-9,
//  10 skip, 11 reverse, 12 draw-two, 13 wild, 14 wild-draw-four). Sits directly downstream of
//  the card deck: requests draws, captures dealt cards, checks legality against the discard
//  top, and emits played cards (o_played/o_played_card feed the deck's insert/prev-card inputs).

---
 rtl/uno_player_hand_if.sv | 35 +++
 rtl/uno_player_hand.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/uno_player_hand_if.sv
// rtl/uno_player_hand_if.sv - control, deck and play signal bundle for the UNO player hand
interface uno_player_hand_if #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 5
);
  logic [2:0]       i_draw_req;
  logic [2:0]       o_deck_draw;
  logic             i_deck_drawn;
  logic [5:0]       i_deck_card;
  logic             i_play;
  logic [IDX_W-1:0] i_sel_idx;
  logic [5:0]       i_top_card;
  logic [5:0]       o_sel_card;
  logic             o_sel_playable;
  logic             o_played;
  logic [5:0]       o_played_card;
  logic             o_reject;
  logic             o_overflow;
  logic [CNT_W-1:0] o_count;
  logic             o_busy;

  // The hand itself
  modport slave (
    input  i_draw_req, i_deck_drawn, i_deck_card, i_play, i_sel_idx, i_top_card,
    output o_deck_draw, o_sel_card, o_sel_playable, o_played, o_played_card,
    output o_reject, o_overflow, o_count, o_busy
  );

  // Game controller / deck side
  modport master (
    output i_draw_req, i_deck_drawn, i_deck_card, i_play, i_sel_idx, i_top_card,
    input  o_deck_draw, o_sel_card, o_sel_playable, o_played, o_played_card,
    input  o_reject, o_overflow, o_count, o_busy
  );
endinterface

// File: rtl/uno_player_hand.sv
// rtl/uno_player_hand.sv - one player's UNO hand: draws from the deck, legality check, plays cards
module uno_player_hand #(
  parameter int MAX_CARDS = 16,
  parameter int IDX_W     = 4,
  parameter int CNT_W     = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  uno_player_hand_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_PLAY} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [5:0]       hand [MAX_CARDS];
  logic [CNT_W-1:0] count;
  logic [2:0]       draw_code;
  logic [2:0]       need;
  logic [5:0]       played_card;
  logic             reject_q;
  logic             overflow_q;

  logic             sel_in_range;
  logic [5:0]       sel_card;
  logic             sel_ok;
  logic             hand_full;
  logic             strobe_take;
  logic             draw_start;
  logic             play_go;
  logic             reject_set;
  logic [2:0]       req_code;

  // Wild and wild-draw-four match anything; otherwise colour or value must match the top
  function automatic logic is_legal(input logic [5:0] card, input logic [5:0] top);
    return (card[3:0] == 4'd13) || (card[3:0] == 4'd14) ||
           (card[5:4] == top[5:4]) || (card[3:0] == top[3:0]);
  endfunction

  assign sel_in_range = CNT_W'(bus.i_sel_idx) < count;
  assign sel_card     = sel_in_range ? hand[bus.i_sel_idx] : 6'd0;
  assign sel_ok       = sel_in_range && is_legal(sel_card, bus.i_top_card);
  assign hand_full    = (count == CNT_W'(MAX_CARDS));
  assign strobe_take  = (state == S_DRAW) && (need != 3'd0) && bus.i_deck_drawn;

  // A multi-bit draw request collapses to its highest set bit; the code also equals the card count
  assign req_code = bus.i_draw_req[2] ? 3'b100 :
                    bus.i_draw_req[1] ? 3'b010 : 3'b001;

  // Next-state and per-cycle control decode; draw outranks play in the same cycle
  always_comb begin
    state_nxt  = state;
    draw_start = 1'b0;
    play_go    = 1'b0;
    reject_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_draw_req != 3'd0) begin
          draw_start = 1'b1;
          reject_set = bus.i_play;
          state_nxt  = S_DRAW;
        end else if (bus.i_play) begin
          if (sel_ok) begin
            play_go   = 1'b1;
            state_nxt = S_PLAY;
          end else begin
            reject_set = 1'b1;
          end
        end
      end
      S_DRAW: begin
        reject_set = bus.i_play;
        if (need == 3'd0) state_nxt = S_IDLE;
      end
      S_PLAY: begin
        reject_set = bus.i_play;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Draw bookkeeping, card count, played-card capture and the one-cycle status pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count       <= '0;
      draw_code   <= 3'd0;
      need        <= 3'd0;
      played_card <= 6'd0;
      reject_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      reject_q   <= reject_set;
      overflow_q <= strobe_take && hand_full;
      if (draw_start) begin
        draw_code <= req_code;
        need      <= req_code;
      end else if (strobe_take) begin
        need <= need - 3'd1;
      end
      if (strobe_take && !hand_full) begin
        count <= count + CNT_W'(1);
      end else if (play_go) begin
        count <= count - CNT_W'(1);
      end
      if (play_go) played_card <= sel_card;
    end
  end

  // Hand storage: append dealt cards at the tail, close the gap when a card is played.
  // Entries at and beyond count are always 0, so shifting hand[i+1] down is safe at the tail.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MAX_CARDS; i++) hand[i] <= 6'd0;
    end else if (strobe_take && !hand_full) begin
      hand[count[IDX_W-1:0]] <= bus.i_deck_card;
    end else if (play_go) begin
      for (int i = 0; i < MAX_CARDS - 1; i++) begin
        if (i >= int'(bus.i_sel_idx)) hand[i] <= hand[i+1];
      end
      hand[MAX_CARDS-1] <= 6'd0;
    end
  end

  assign bus.o_deck_draw    = ((state == S_DRAW) && (need != 3'd0)) ? draw_code : 3'd0;
  assign bus.o_sel_card     = sel_card;
  assign bus.o_sel_playable = sel_ok;
  assign bus.o_played       = (state == S_PLAY);
  assign bus.o_played_card  = (state == S_PLAY) ? played_card : 6'd0;
  assign bus.o_reject       = reject_q;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_count        = count;
  assign bus.o_busy         = (state != S_IDLE);

endmodule
